// File: rtl/mctrl_gen.sv
// Multi-cycle MIPS control FSM with ALU-op decode, bus-wait timeout, precise traps
// and external interrupt entry; all controls are registered alongside the state.
module mctrl_gen #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_ON_OVF = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Inst_in,
  input  logic                zero,
  input  logic                overflow,
  input  logic                MIO_ready,
  input  logic                int_req,
  output logic                int_ack,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                CPU_MIO,
  output logic                IorD,
  output logic                IRWrite,
  output logic [ALU_OP_W-1:0] ALU_operation,
  output logic [1:0]          RegDst,
  output logic                RegWrite,
  output logic [1:0]          MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                Branch,
  output logic                EPCWrite,
  output logic [1:0]          cause,
  output logic [4:0]          state_out
);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MEM_EX = 5'd2, S_MEM_RD = 5'd3, S_LW_WB = 5'd4,
    S_MEM_WR = 5'd5, S_R_EXE = 5'd6, S_R_WB = 5'd7, S_BR_EXE = 5'd8, S_J = 5'd9,
    S_I_EXE = 5'd10, S_I_WB = 5'd11, S_LUI_WB = 5'd12, S_JR = 5'd13, S_JAL = 5'd14,
    S_TRAP = 5'd16
  } state_t;

  typedef struct packed {
    logic                mem_read;
    logic                mem_write;
    logic                cpu_mio;
    logic                iord;
    logic                pc_write;
    logic                pc_write_cond;
    logic                reg_write;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_source;
    logic                epc_write;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t               state, nxt, dec_st;
  ctrl_t                ctrl_q;
  logic [1:0]           nxt_cause;
  logic [CNT_W-1:0]     cnt;
  logic                 chk_ovf, dec_ovf, timeout, if_fetch;
  logic [3:0]           dec_code;
  logic [ALU_OP_W-1:0]  dec_alu;
  logic [5:0]           op_f, fn;
  logic                 unused_bits;

  function automatic logic is_wait(input state_t s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input logic [ALU_OP_W-1:0] op);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (s)
      S_IF:     begin c.mem_read = 1'b1; c.cpu_mio = 1'b1; c.alu_src_b = 2'b01; end
      S_ID:     c.alu_src_b = 2'b11;
      S_MEM_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD: begin c.iord = 1'b1; c.mem_read = 1'b1; c.cpu_mio = 1'b1; end
      S_LW_WB:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      S_MEM_WR: begin c.iord = 1'b1; c.mem_write = 1'b1; c.cpu_mio = 1'b1; end
      S_R_EXE:  begin c.alu_src_a = 1'b1; c.alu_op = op; end
      S_R_WB:   begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      S_BR_EXE: begin
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_J:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_I_EXE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op; end
      S_I_WB:   c.reg_write = 1'b1;
      S_LUI_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 2'b10; end
      S_JR:     begin c.alu_src_a = 1'b1; c.pc_write = 1'b1; end
      S_JAL:    begin
        c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = 1'b1;
        c.reg_dst = 2'b10; c.mem_to_reg = 2'b11;
      end
      S_TRAP:   begin c.epc_write = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b11; end
      default:  c.alu_op = ALU_ADD;
    endcase
    return c;
  endfunction

  assign op_f = Inst_in[31:26];
  assign fn   = Inst_in[5:0];
  // zero feeds the datapath's branch gate directly; the FSM only exports Branch.
  assign unused_bits = ^{Inst_in[25:6], zero};

  always_comb begin
    dec_st   = S_TRAP;
    dec_code = 4'd2;
    dec_ovf  = 1'b0;
    case (op_f)
      6'h00: case (fn)
        6'h20: begin dec_st = S_R_EXE; dec_code = 4'd2; dec_ovf = 1'b1; end
        6'h22: begin dec_st = S_R_EXE; dec_code = 4'd6; dec_ovf = 1'b1; end
        6'h24: begin dec_st = S_R_EXE; dec_code = 4'd0; end
        6'h25: begin dec_st = S_R_EXE; dec_code = 4'd1; end
        6'h26: begin dec_st = S_R_EXE; dec_code = 4'd3; end
        6'h27: begin dec_st = S_R_EXE; dec_code = 4'd4; end
        6'h2A: begin dec_st = S_R_EXE; dec_code = 4'd8; end
        6'h2B: begin dec_st = S_R_EXE; dec_code = 4'd7; end
        6'h02: begin dec_st = S_R_EXE; dec_code = 4'd5; end
        6'h00: begin dec_st = S_R_EXE; dec_code = 4'd9; end
        6'h03: begin dec_st = S_R_EXE; dec_code = 4'd10; end
        6'h08: dec_st = S_JR;
        default: dec_st = S_TRAP;
      endcase
      6'h08: begin dec_st = S_I_EXE; dec_code = 4'd2; dec_ovf = 1'b1; end
      6'h0C: begin dec_st = S_I_EXE; dec_code = 4'd0; end
      6'h0D: begin dec_st = S_I_EXE; dec_code = 4'd1; end
      6'h0E: begin dec_st = S_I_EXE; dec_code = 4'd3; end
      6'h0A: begin dec_st = S_I_EXE; dec_code = 4'd8; end
      6'h0B: begin dec_st = S_I_EXE; dec_code = 4'd7; end
      6'h0F: dec_st = S_LUI_WB;
      6'h23, 6'h2B: dec_st = S_MEM_EX;
      6'h04, 6'h05: dec_st = S_BR_EXE;
      6'h02: dec_st = S_J;
      6'h03: dec_st = S_JAL;
      default: dec_st = S_TRAP;
    endcase
    // An op code too wide for the ALU port is an illegal instruction on this build.
    if ((dec_st == S_R_EXE || dec_st == S_I_EXE) && !(int'(dec_code) < (1 << ALU_OP_W)))
      dec_st = S_TRAP;
  end

  assign dec_alu = ALU_OP_W'(dec_code);
  assign timeout = (MEM_TIMEOUT != 0) && !MIO_ready && (cnt == TO_LAST);

  always_comb begin
    nxt       = state;
    nxt_cause = cause;
    case (state)
      S_IF: begin
        if (int_req)        begin nxt = S_TRAP; nxt_cause = 2'd0; end
        else if (MIO_ready) nxt = S_ID;
        else if (timeout)   begin nxt = S_TRAP; nxt_cause = 2'd3; end
      end
      S_ID: begin
        nxt = dec_st;
        if (dec_st == S_TRAP) nxt_cause = 2'd1;
      end
      S_MEM_EX: nxt = (op_f == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MIO_ready)    nxt = S_LW_WB;
        else if (timeout) begin nxt = S_TRAP; nxt_cause = 2'd3; end
      end
      S_MEM_WR: begin
        if (MIO_ready)    nxt = S_IF;
        else if (timeout) begin nxt = S_TRAP; nxt_cause = 2'd3; end
      end
      S_R_EXE, S_I_EXE: begin
        if (chk_ovf && overflow && (TRAP_ON_OVF != 0)) begin
          nxt = S_TRAP; nxt_cause = 2'd2;
        end else begin
          nxt = (state == S_R_EXE) ? S_R_WB : S_I_WB;
        end
      end
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IF;
      ctrl_q  <= ctrl_of(S_IF, ALU_ADD);
      cause   <= 2'd0;
      cnt     <= '0;
      Branch  <= 1'b0;
      int_ack <= 1'b0;
      chk_ovf <= 1'b0;
    end else begin
      state   <= nxt;
      ctrl_q  <= ctrl_of(nxt, dec_alu);
      cause   <= nxt_cause;
      int_ack <= (nxt == S_TRAP) && (nxt_cause == 2'd0);
      if (state == S_ID) chk_ovf <= dec_ovf;
      if (state == S_ID && nxt == S_BR_EXE) Branch <= (op_f == 6'h04);
      if (nxt != state && is_wait(nxt))          cnt <= '0;
      else if (is_wait(state) && !MIO_ready)     cnt <= cnt + CNT_W'(1);
    end
  end

  // PC/IR load only on the cycle the fetch completes, so a stalled IF never double-writes.
  assign if_fetch      = (state == S_IF) && MIO_ready && !int_req && reset;
  assign PCWrite       = ctrl_q.pc_write | if_fetch;
  assign IRWrite       = if_fetch;
  assign MemRead       = ctrl_q.mem_read;
  assign MemWrite      = ctrl_q.mem_write;
  assign CPU_MIO       = ctrl_q.cpu_mio;
  assign IorD          = ctrl_q.iord;
  assign ALU_operation = ctrl_q.alu_op;
  assign RegDst        = ctrl_q.reg_dst;
  assign RegWrite      = ctrl_q.reg_write;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign PCSource      = ctrl_q.pc_source;
  assign PCWriteCond   = ctrl_q.pc_write_cond;
  assign EPCWrite      = ctrl_q.epc_write;
  assign state_out     = state;

endmodule

// File: tb/tb_mctrl_gen.sv
// Random-stimulus bench for mctrl_gen: two builds (default, and narrow ALU / short
// timeout / no overflow trap) run against an instruction-level reference model.
module tb_mctrl_gen;

  logic        clk = 1'b0;
  logic        reset, zero, overflow, MIO_ready, int_req;
  logic [31:0] ins [2];
  logic [1:0]  int_ack, MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  PCWrite, PCWriteCond, Branch, EPCWrite;
  logic [1:0]  RegDst [2], MemtoReg [2], ALUSrcB [2], PCSource [2], cause [2];
  logic [4:0]  state_out [2];
  logic [3:0]  alu0;
  logic [2:0]  alu1;

  always #5 clk = ~clk;

  mctrl_gen u0 (
    .clk(clk), .reset(reset), .Inst_in(ins[0]), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .int_ack(int_ack[0]), .MemRead(MemRead[0]),
    .MemWrite(MemWrite[0]), .CPU_MIO(CPU_MIO[0]), .IorD(IorD[0]), .IRWrite(IRWrite[0]),
    .ALU_operation(alu0), .RegDst(RegDst[0]), .RegWrite(RegWrite[0]), .MemtoReg(MemtoReg[0]),
    .ALUSrcA(ALUSrcA[0]), .ALUSrcB(ALUSrcB[0]), .PCSource(PCSource[0]), .PCWrite(PCWrite[0]),
    .PCWriteCond(PCWriteCond[0]), .Branch(Branch[0]), .EPCWrite(EPCWrite[0]),
    .cause(cause[0]), .state_out(state_out[0])
  );

  mctrl_gen #(.ALU_OP_W(3), .MEM_TIMEOUT(4), .TRAP_ON_OVF(0)) u1 (
    .clk(clk), .reset(reset), .Inst_in(ins[1]), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .int_ack(int_ack[1]), .MemRead(MemRead[1]),
    .MemWrite(MemWrite[1]), .CPU_MIO(CPU_MIO[1]), .IorD(IorD[1]), .IRWrite(IRWrite[1]),
    .ALU_operation(alu1), .RegDst(RegDst[1]), .RegWrite(RegWrite[1]), .MemtoReg(MemtoReg[1]),
    .ALUSrcA(ALUSrcA[1]), .ALUSrcB(ALUSrcB[1]), .PCSource(PCSource[1]), .PCWrite(PCWrite[1]),
    .PCWriteCond(PCWriteCond[1]), .Branch(Branch[1]), .EPCWrite(EPCWrite[1]),
    .cause(cause[1]), .state_out(state_out[1])
  );

  int P_OPW [2] = '{4, 3};
  int P_TMO [2] = '{16, 4};
  int P_TOV [2] = '{1, 0};

  int r_alu [int];
  int i_alu [int];
  logic [5:0] R_FN [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                            6'h02, 6'h00, 6'h03, 6'h08, 6'h01};
  logic [5:0] OPS [15]  = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h23,
                            6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h01};

  int m_st [2], m_cause [2], m_wait [2], m_alu [2];
  bit m_br [2], m_ovf [2];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [30:0] got, input logic [30:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] obs(input int i);
    logic [3:0] a;
    a = (i == 0) ? alu0 : {1'b0, alu1};
    return {int_ack[i], MemRead[i], MemWrite[i], CPU_MIO[i], IorD[i], IRWrite[i], a,
            RegDst[i], RegWrite[i], MemtoReg[i], ALUSrcA[i], ALUSrcB[i], PCSource[i],
            PCWrite[i], PCWriteCond[i], Branch[i], EPCWrite[i], cause[i], state_out[i]};
  endfunction

  // Instruction class -> target state, ALU code and overflow sensitivity.
  function automatic int dec(input logic [31:0] w, input int opw, output int alu, output bit ovf);
    int op, fnc, t;
    op = int'(w[31:26]); fnc = int'(w[5:0]);
    alu = 2; ovf = 1'b0; t = 16;
    if (op == 0) begin
      if (fnc == 8) t = 13;
      else if (r_alu.exists(fnc)) begin t = 6; alu = r_alu[fnc]; ovf = (fnc == 32 || fnc == 34); end
    end else if (i_alu.exists(op)) begin
      t = 10; alu = i_alu[op]; ovf = (op == 8);
    end else begin
      case (op)
        15: t = 12;
        35, 43: t = 2;
        4, 5: t = 8;
        2: t = 9;
        3: t = 14;
        default: t = 16;
      endcase
    end
    if ((t == 6 || t == 10) && alu >= (1 << opw)) t = 16;
    return t;
  endfunction

  function automatic logic [30:0] expect_vec(input int i);
    logic mr, mw, mio, iord, irw, rw, sa, pw, pwc, epc, ack;
    logic [3:0] a;
    logic [1:0] rdst, m2r, sb, ps;
    {mr, mw, mio, iord, irw, rw, sa, pw, pwc, epc} = '0;
    a = 4'd2; rdst = 2'd0; m2r = 2'd0; sb = 2'd0; ps = 2'd0;
    case (m_st[i])
      0:  begin mr = 1; mio = 1; sb = 2'd1; pw = reset && MIO_ready && !int_req; irw = pw; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin iord = 1; mr = 1; mio = 1; end
      4:  begin rw = 1; m2r = 2'd1; end
      5:  begin iord = 1; mw = 1; mio = 1; end
      6:  begin sa = 1; a = 4'(m_alu[i]); end
      7:  begin rw = 1; rdst = 2'd1; end
      8:  begin sa = 1; a = 4'd6; pwc = 1; ps = 2'd1; end
      9:  begin pw = 1; ps = 2'd2; end
      10: begin sa = 1; sb = 2'd2; a = 4'(m_alu[i]); end
      11: rw = 1;
      12: begin rw = 1; m2r = 2'd2; end
      13: begin sa = 1; pw = 1; end
      14: begin pw = 1; ps = 2'd2; rw = 1; rdst = 2'd2; m2r = 2'd3; end
      16: begin epc = 1; pw = 1; ps = 2'd3; end
      default: a = 4'd2;
    endcase
    ack = (m_st[i] == 16) && (m_cause[i] == 0);
    return {ack, mr, mw, mio, iord, irw, a, rdst, rw, m2r, sa, sb, ps, pw, pwc,
            m_br[i], epc, 2'(m_cause[i]), 5'(m_st[i])};
  endfunction

  task automatic mreset(input int i);
    m_st[i] = 0; m_cause[i] = 0; m_wait[i] = 0; m_br[i] = 0; m_alu[i] = 2; m_ovf[i] = 0;
  endtask

  task automatic trap(input int i, input int c);
    m_st[i] = 16; m_cause[i] = c;
  endtask

  task automatic step(input int i);
    bit expired;
    int t, a;
    bit o;
    expired = (P_TMO[i] > 0) && (m_wait[i] == P_TMO[i] - 1) && !MIO_ready;
    case (m_st[i])
      0: begin
        if (int_req)        trap(i, 0);
        else if (MIO_ready) m_st[i] = 1;
        else if (expired)   trap(i, 3);
        else                m_wait[i]++;
      end
      1: begin
        t = dec(ins[i], P_OPW[i], a, o);
        if (t == 16) trap(i, 1);
        else begin
          if (t == 8) m_br[i] = (ins[i][31:26] == 6'h04);
          m_alu[i] = a; m_ovf[i] = o; m_st[i] = t;
        end
      end
      2: begin m_st[i] = (ins[i][31:26] == 6'h2B) ? 5 : 3; m_wait[i] = 0; end
      3, 5: begin
        if (MIO_ready)    begin m_st[i] = (m_st[i] == 3) ? 4 : 0; m_wait[i] = 0; end
        else if (expired) trap(i, 3);
        else              m_wait[i]++;
      end
      6, 10: begin
        if (m_ovf[i] && overflow && P_TOV[i] != 0) trap(i, 2);
        else m_st[i] = m_st[i] + 1;
      end
      default: begin m_st[i] = 0; m_wait[i] = 0; end
    endcase
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 4) begin
      w[31:26] = 6'h00;
      w[5:0]   = R_FN[$urandom_range(0, 12)];
    end else begin
      w[31:26] = OPS[$urandom_range(0, 14)];
    end
    return w;
  endfunction

  initial begin
    int stall;
    r_alu[32] = 2; r_alu[34] = 6; r_alu[36] = 0; r_alu[37] = 1; r_alu[38] = 3;
    r_alu[39] = 4; r_alu[42] = 8; r_alu[43] = 7; r_alu[2] = 5; r_alu[0] = 9; r_alu[3] = 10;
    i_alu[8] = 2; i_alu[12] = 0; i_alu[13] = 1; i_alu[14] = 3; i_alu[10] = 8; i_alu[11] = 7;
    reset = 1'b0; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b0; int_req = 1'b0;
    ins[0] = '0; ins[1] = '0; stall = 0;
    mreset(0); mreset(1);
    repeat (2) @(negedge clk);
    #1;
    chk("u0 reset", obs(0), expect_vec(0));
    chk("u1 reset", obs(1), expect_vec(1));

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; mreset(0); mreset(1);
      end
      if (stall > 0) stall--;
      else if ($urandom_range(0, 39) == 0) stall = $urandom_range(2, 20);
      MIO_ready = (stall == 0) && ($urandom_range(0, 3) != 0);
      int_req   = ($urandom_range(0, 49) == 0);
      overflow  = ($urandom_range(0, 2) == 0);
      zero      = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 2; i++)
        if (m_st[i] == 0) ins[i] = rand_ins();
      #1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("u%0d cyc%0d st%0d ins%h", i, cyc, m_st[i], ins[i]), obs(i), expect_vec(i));
      if (reset) begin
        step(0);
        step(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mctrl_gen.md
Name: mctrl_gen

Overview:
- Parametrised next-generation multi-cycle MIPS control FSM, driving the shared multi-cycle datapath (PC/IR/MDR/A/B/ALUOut, register file, ALU, MIO bus).
- Adds wider ALU op codes (SLT, SLL, SRA), a bus-wait timeout, overflow/illegal-instruction traps, an external interrupt, and exception-vector PC loading with EPC/cause capture.
- Fixes PC/IR double-write while waiting in IF.

Parameters:
ALU_OP_W, 4, ALU_operation width. At 3, ops with code ≥ 8 decode as illegal.
MEM_TIMEOUT, 16, max MIO_ready-low cycles in a wait state before bus-error trap. 0 disables the timeout.
TRAP_ON_OVF, 1, 1 = ADD/SUB/ADDI overflow traps. 0 = overflow ignored.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Inst_in  in  32  IR contents
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow, valid in the execute cycle
MIO_ready  in  1  bus ready
int_req  in  1  level interrupt request
int_ack  out  1  one-cycle pulse in TRAP when cause=0
MemRead, MemWrite, CPU_MIO, IorD, IRWrite  out  1 each  memory/IR control
ALU_operation  out  ALU_OP_W  ALU op: ADD 2, SUB 6, AND 0, OR 1, XOR 3, NOR 4, SRL 5, SLTU 7, SLT 8, SLL 9, SRA 10
RegDst  out  2  00 rt, 01 rd, 10 $31
RegWrite  out  1  register file write
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 imm<<16, 11 PC
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
PCWrite, PCWriteCond, Branch  out  1 each  PC update; Branch=1 BEQ, 0 BNE
EPCWrite  out  1  EPC <= PC
cause  out  2  0 interrupt, 1 illegal, 2 overflow, 3 bus timeout (held until next trap)
state_out  out  5  current state code

Behaviour:
- States (code): IF0 ID1 MEM_EX2 MEM_RD3 LW_WB4 MEM_WR5 R_EXE6 R_WB7 BR_EXE8 J9 I_EXE10 I_WB11 LUI_WB12 JR13 JAL14 TRAP16.
- All outputs are registered with state; values below apply while in that state.
- Reset (reset=0, asynchronous):
  - state IF, cause 0, timeout counter 0, Branch 0, int_ack 0, EPCWrite 0.
  - IF outputs: MemRead 1, CPU_MIO 1, ALUSrcB 01, ALU ADD, everything else 0.
- IF:
  - PCWrite and IRWrite are asserted only in a cycle where MIO_ready=1 (qualified combinationally).
  - int_req=1 has priority: go to TRAP, cause 0, no PC/IR write.
  - Else MIO_ready=1: go to ID.
  - Else stay and count.
- ID: ALUSrcA 0, ALUSrcB 11, ALU ADD (branch target into ALUOut). Decode:
  - R-type funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 02 SRL, 00 SLL, 03 SRA → R_EXE. Funct 08 → JR.
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU → I_EXE.
  - LUI → LUI_WB. LW/SW → MEM_EX.
  - BEQ/BNE → BR_EXE (Branch set 1/0).
  - J → J. JAL → JAL.
  - Anything else, or any op whose code does not fit ALU_OP_W → TRAP, cause 1.
- R_EXE: ALUSrcA 1, ALUSrcB 00.
  - ADD/SUB with overflow=1 and TRAP_ON_OVF=1 → TRAP, cause 2, no RegWrite.
  - Else → R_WB (RegWrite 1, RegDst 01, MemtoReg 00).
- I_EXE: ALUSrcB 10, same overflow rule for ADDI. → I_WB (RegDst 00).
- MEM_EX: address computed. LW → MEM_RD (IorD 1, MemRead 1). SW → MEM_WR (IorD 1, MemWrite 1).
- MEM_RD: hold until MIO_ready → LW_WB (MemtoReg 01, RegWrite 1).
- MEM_WR: hold until MIO_ready → IF.
- BR_EXE: ALU SUB, PCWriteCond 1, PCSource 01.
- J: PCWrite 1, PCSource 10.
- JAL: as J, plus RegWrite 1, RegDst 10, MemtoReg 11.
- JR: ALUSrcA 1, PCWrite 1, PCSource 00.
- LUI_WB: RegWrite 1, MemtoReg 10.
- TRAP: EPCWrite 1, PCWrite 1, PCSource 11, cause updated, int_ack=(cause==0). → IF.
- All WB/jump/branch states → IF after one cycle.
- Timeout:
  - Counter clears on entering IF, MEM_RD or MEM_WR, and increments each cycle MIO_ready=0 there.
  - Count reaching MEM_TIMEOUT-1 with MIO_ready=0 → TRAP, cause 3; MemRead/MemWrite drop in TRAP.
  - MIO_ready=1 in that same cycle wins over the timeout.
- Simultaneous events: int_req is sampled only in IF. Overflow and illegal-instruction traps are precise, with no register-file write.
- Reset mid-operation forces IF values immediately, with no EPC write.

Test Plan:
- Reset low mid-MEM_RD → state_out=0, MemRead=1, RegWrite=0, cause=0 immediately. Release, MIO_ready=1 → ID next cycle, exactly one PCWrite pulse.
- IF with MIO_ready low 3 cycles, then high (MEM_TIMEOUT=16) → PCWrite/IRWrite high only in the 4th cycle, state 1 next.
- ADD (funct 20) with overflow=1 in R_EXE → state 16, cause=2, EPCWrite=1, PCSource=11, then IF. With TRAP_ON_OVF=0 → R_WB, RegWrite=1.
- LW with MIO_ready stuck low, MEM_TIMEOUT=4 → TRAP after 4 MEM_RD cycles, cause=3. With MIO_ready=1 on the 4th cycle → LW_WB instead.
- Opcode 0x3F → TRAP, cause=1. SLT with ALU_OP_W=3 → cause=1. With ALU_OP_W=4 → ALU_operation=8.
- int_req=1 entering IF → TRAP, cause=0, int_ack one cycle, no IRWrite. BNE with zero=0 → Branch=0, PCWriteCond=1 in state 8.
